// File: rtl/fetch_xmit.sv
// fetch_xmit: PC sequencer, in-order imem requester and output queue feeding decode, with nuke/resume.
// Optional FETCH_XMIT_EBREAK_HALT_EN: stop fetching once an EBREAK has been sent to decode.
module fetch_xmit #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           nuke_rb1,          // {valid, nuke_fe}
  input  logic                 resume_fetch_rbx,
  input  logic [ADDR_W-1:0]    resume_pc_rbx,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ADDR_W-1:0]    imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  input  logic                 decode_ready_de0,
  output logic                 valid_fe1,
  output logic [32+ADDR_W-1:0] instr_fe1          // {instr, pc}
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
`ifdef FETCH_XMIT_EBREAK_HALT_EN
  localparam logic [1:0]  ST_HALT = 2'd3;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
`endif

  logic [1:0]           state_q, state_d;
  logic                 run_en_q;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [CW-1:0]        out_q, out_d, q_cnt_q, q_cnt_d;
  logic [PW-1:0]        q_wr_q, q_rd_q, pcf_wr_q, pcf_rd_q;
  logic [32+ADDR_W-1:0] q_mem [DEPTH];
  logic [ADDR_W-1:0]    pcf_mem [DEPTH];
  logic [32+ADDR_W-1:0] head;
  logic                 nuke, credit_ok, req_fire, push, pop, flush, q_empty;

  assign nuke      = nuke_rb1[1] & nuke_rb1[0];
  assign q_empty   = (q_cnt_q == '0);
  assign head      = q_mem[q_rd_q];
  // Credits cover queued words plus words still in flight, so every response has a slot.
  assign credit_ok = ({1'b0, q_cnt_q} + {1'b0, out_q}) < DEPTH_C;

  // run_en_q holds requests off for the first cycle out of reset so all outputs start at 0.
  assign imem_req_valid = run_en_q & (state_q == ST_RUN) & credit_ok & ~nuke;
  assign imem_req_addr  = imem_req_valid ? pc_q : '0;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign push      = imem_rsp_valid & (state_q == ST_RUN);
  assign valid_fe1 = ~q_empty & decode_ready_de0 & ~nuke;
  assign pop       = valid_fe1;
  assign instr_fe1 = q_empty ? '0 : head;

  assign out_d   = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
  assign q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    pc_d    = req_fire ? pc_q + ADDR_W'(4) : pc_q;
    flush   = nuke;
    if (nuke) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
`ifdef FETCH_XMIT_EBREAK_HALT_EN
        ST_RUN: begin
          if (pop && head[32+ADDR_W-1:ADDR_W] == EBREAK) begin
            state_d = ST_HALT;
            flush   = 1'b1;
          end
        end
`endif
        ST_FLUSH: begin
          if (resume_fetch_rbx) begin
            pc_d    = resume_pc_rbx;
            state_d = (out_d == '0) ? ST_RUN : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_d == '0) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      run_en_q <= 1'b0;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      q_cnt_q  <= '0;
      q_wr_q   <= '0;
      q_rd_q   <= '0;
      pcf_wr_q <= '0;
      pcf_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      run_en_q <= 1'b1;
      pc_q     <= pc_d;
      out_q    <= out_d;
      if (flush) begin
        q_cnt_q  <= '0;
        q_wr_q   <= '0;
        q_rd_q   <= '0;
        pcf_wr_q <= '0;
        pcf_rd_q <= '0;
      end else begin
        q_cnt_q <= q_cnt_d;
        if (push) begin
          q_wr_q   <= q_wr_q + PW'(1);
          pcf_rd_q <= pcf_rd_q + PW'(1);
        end
        if (pop)      q_rd_q   <= q_rd_q + PW'(1);
        if (req_fire) pcf_wr_q <= pcf_wr_q + PW'(1);
      end
    end
  end

  // Storage needs no reset: the pointers and counts decide what is live.
  always_ff @(posedge clk) begin
    if (push)     q_mem[q_wr_q]     <= {imem_rsp_data, pcf_mem[pcf_rd_q]};
    if (req_fire) pcf_mem[pcf_wr_q] <= pc_q;
  end

endmodule

// File: tb/tb_fetch_xmit.sv
// Directed bench for fetch_xmit: a fixed-latency in-order memory model feeds the DUT;
// a second instance with RESET_PC=0xFFFF_FFFC checks PC wrap.
module tb_fetch_xmit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  nuke = 2'b00;
  logic        resume = 1'b0;
  logic [31:0] resume_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        decode_ready = 1'b1;
  logic        valid_fe1;
  logic [63:0] instr_fe1;

  logic        w_req_valid, w_valid;
  logic [31:0] w_req_addr;
  logic [63:0] w_instr;

  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  int vectors = 0;
  int miscompares = 0;
  int issued = 0, sent = 0, responded = 0;

  logic [2:0]  lat_m1 = 3'd0;
  logic [31:0] ebreak_pc = 32'h1;
  logic [7:0]  pv;
  logic [31:0] pa [8];

  always #5 clk = ~clk;

  fetch_xmit #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .reset_n(reset_n), .nuke_rb1(nuke),
    .resume_fetch_rbx(resume), .resume_pc_rbx(resume_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .decode_ready_de0(decode_ready),
    .valid_fe1(valid_fe1), .instr_fe1(instr_fe1)
  );

  fetch_xmit #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset_n(reset_n), .nuke_rb1(2'b00),
    .resume_fetch_rbx(1'b0), .resume_pc_rbx(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(1'b0),
    .imem_rsp_data(32'h0), .decode_ready_de0(1'b1),
    .valid_fe1(w_valid), .instr_fe1(w_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a, input logic [31:0] eb);
    return (a == eb) ? 32'h0010_0073 : ~a;
  endfunction

  // Memory: response appears lat_m1+1 cycles after the request handshake.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pv <= '0;
    else          pv <= {pv[6:0], imem_req_valid & imem_req_ready};
  end
  always @(posedge clk) begin
    pa[0] <= imem_req_addr;
    for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
  end
  assign imem_rsp_valid = pv[lat_m1];
  assign imem_rsp_data  = instr_of(pa[lat_m1], ebreak_pc);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued <= 0; sent <= 0; responded <= 0;
    end else begin
      if (imem_req_valid && imem_req_ready) issued <= issued + 1;
      if (valid_fe1)      sent <= sent + 1;
      if (imem_rsp_valid) responded <= responded + 1;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 30 && !imem_req_valid; i++) tick();
  endtask

  task automatic wait_send();
    for (int i = 0; i < 30 && !valid_fe1; i++) tick();
  endtask

  task automatic test_reset();
    lat_m1 = 3'd0; decode_ready = 1'b1; imem_req_ready = 1'b1; ebreak_pc = 32'h1;
    apply_reset();
    repeat (5) tick();
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL reset_req_addr got=%h exp=0", imem_req_addr); end
    vectors++; if (valid_fe1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid_fe1 got=%b exp=0", valid_fe1); end
    vectors++; if (instr_fe1 !== 64'h0) begin miscompares++; $display("FAIL reset_instr_fe1 got=%h exp=0", instr_fe1); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_first_cycle_req got=%b exp=0", imem_req_valid); end
    $display("test_reset done");
  endtask

  task automatic test_steady();
    logic exp_valid;
    logic [31:0] exp_pc;
    ebreak_pc = 32'h108; lat_m1 = 3'd0; decode_ready = 1'b1; imem_req_ready = 1'b1;
    apply_reset();
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) begin
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL steady_first_req got=%b/%h exp=1/00000100", imem_req_valid, imem_req_addr); end
      end
`ifdef FETCH_XMIT_EBREAK_HALT_EN
      exp_valid = (n >= 3 && n <= 5);
      if (n >= 6) begin
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL halt_no_req n=%0d got=%b exp=0", n, imem_req_valid); end
      end
`else
      exp_valid = (n >= 3);
`endif
      exp_pc = 32'h100 + 32'(4 * (n - 3));
      vectors++; if (valid_fe1 !== exp_valid) begin miscompares++; $display("FAIL steady_valid n=%0d got=%b exp=%b", n, valid_fe1, exp_valid); end
      if (exp_valid) begin
        vectors++; if (instr_fe1[31:0] !== exp_pc || instr_fe1[63:32] !== instr_of(exp_pc, 32'h108)) begin miscompares++; $display("FAIL steady_pkt n=%0d got=%h exp_pc=%h", n, instr_fe1, exp_pc); end
        $display("send pc=%h instr=%h", instr_fe1[31:0], instr_fe1[63:32]);
      end
    end
  endtask

`ifdef FETCH_XMIT_EBREAK_HALT_EN
  task automatic test_ebreak();
    nuke = 2'b11;
    tick();
    nuke = 2'b00; resume = 1'b1; resume_pc = 32'h40;
    tick();
    resume = 1'b0;
    wait_req();
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin miscompares++; $display("FAIL ebreak_restart_req got=%b/%h exp=1/00000040", imem_req_valid, imem_req_addr); end
    wait_send();
    vectors++; if (valid_fe1 !== 1'b1 || instr_fe1[31:0] !== 32'h40) begin miscompares++; $display("FAIL ebreak_restart_send got=%b/%h exp=1/00000040", valid_fe1, instr_fe1[31:0]); end
    $display("test_ebreak done");
  endtask
`endif

  task automatic test_backpressure();
    ebreak_pc = 32'h1; lat_m1 = 3'd0; decode_ready = 1'b0; imem_req_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++; if (valid_fe1 !== 1'b0) begin miscompares++; $display("FAIL bp_no_send cyc=%0d got=%b exp=0", i, valid_fe1); end
      if (imem_req_valid) begin
        vectors++; if (issued - sent >= 4) begin miscompares++; $display("FAIL bp_credit cyc=%0d inflight=%0d exp<4", i, issued - sent); end
      end
    end
    vectors++; if (issued !== 4) begin miscompares++; $display("FAIL bp_issued got=%0d exp=4", issued); end
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_stalled got=%b exp=0", imem_req_valid); end
    decode_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      vectors++; if (valid_fe1 !== 1'b1 || instr_fe1[31:0] !== 32'h100 + 32'(4 * k)) begin miscompares++; $display("FAIL bp_release k=%0d got=%b/%h exp=1/%h", k, valid_fe1, instr_fe1[31:0], 32'h100 + 32'(4 * k)); end
      $display("send pc=%h", instr_fe1[31:0]);
    end
  endtask

  task automatic test_nuke();
    ebreak_pc = 32'h1; lat_m1 = 3'd4; decode_ready = 1'b1; imem_req_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 20 && issued != 3; i++) tick();
    vectors++; if (issued !== 3) begin miscompares++; $display("FAIL nuke_setup issued=%0d exp=3", issued); end
    nuke = 2'b11;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL nuke_req_suppressed got=%b exp=0", imem_req_valid); end
    tick();
    nuke = 2'b00; resume = 1'b1; resume_pc = 32'h2000;
    #1;
    vectors++; if (u_dut.state_q !== S_FLUSH) begin miscompares++; $display("FAIL nuke_state_flush got=%0d exp=%0d", u_dut.state_q, S_FLUSH); end
    tick();
    resume = 1'b0;
    vectors++; if (u_dut.state_q !== S_DRAIN) begin miscompares++; $display("FAIL nuke_state_drain got=%0d exp=%0d", u_dut.state_q, S_DRAIN); end
    vectors++; if (responded !== 0) begin miscompares++; $display("FAIL nuke_rsp_pending got=%0d exp=0", responded); end
    for (int i = 0; i < 20 && !imem_req_valid; i++) begin
      vectors++; if (valid_fe1 !== 1'b0) begin miscompares++; $display("FAIL drain_no_send cyc=%0d got=%b exp=0", i, valid_fe1); end
      tick();
    end
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin miscompares++; $display("FAIL nuke_restart_req got=%b/%h exp=1/00002000", imem_req_valid, imem_req_addr); end
    vectors++; if (responded !== 3) begin miscompares++; $display("FAIL nuke_stale_drained got=%0d exp=3", responded); end
    wait_send();
    vectors++; if (valid_fe1 !== 1'b1 || instr_fe1 !== {~32'h2000, 32'h2000}) begin miscompares++; $display("FAIL nuke_first_send got=%b/%h exp=1/%h", valid_fe1, instr_fe1, {~32'h2000, 32'h2000}); end
    $display("test_nuke done");
  endtask

  task automatic test_nuke_resume_same();
    tick();
    nuke = 2'b11; resume = 1'b1; resume_pc = 32'h3000;
    #1;
    vectors++; if (valid_fe1 !== 1'b0 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL same_suppress got=%b/%b exp=0/0", valid_fe1, imem_req_valid); end
    tick();
    nuke = 2'b00; resume = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (u_dut.state_q !== S_FLUSH || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL same_hold_flush cyc=%0d got=%0d/%b exp=%0d/0", i, u_dut.state_q, imem_req_valid, S_FLUSH); end
      tick();
    end
    resume = 1'b1; resume_pc = 32'h4000;
    tick();
    resume = 1'b0;
    wait_req();
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4000) begin miscompares++; $display("FAIL same_restart_req got=%b/%h exp=1/00004000", imem_req_valid, imem_req_addr); end
    wait_send();
    vectors++; if (valid_fe1 !== 1'b1 || instr_fe1[31:0] !== 32'h4000) begin miscompares++; $display("FAIL same_first_send got=%b/%h exp=1/00004000", valid_fe1, instr_fe1[31:0]); end
    $display("test_nuke_resume_same done");
  endtask

  task automatic test_wrap();
    lat_m1 = 3'd0;
    apply_reset();
    tick();
    vectors++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", w_req_valid, w_req_addr); end
    tick();
    vectors++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_second got=%b/%h exp=1/00000000", w_req_valid, w_req_addr); end
    vectors++; if (w_valid !== 1'b0 || w_instr !== 64'h0) begin miscompares++; $display("FAIL wrap_no_send got=%b/%h exp=0/0", w_valid, w_instr); end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_steady();
`ifdef FETCH_XMIT_EBREAK_HALT_EN
    test_ebreak();
`endif
    test_backpressure();
    test_nuke();
    test_nuke_resume_same();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
